// File: rtl/tag_alloc_ctrl.sv
// Rename-side allocation controller for the physical-tag free list.
// Grants pre-fetched slots to requesting lanes all-or-nothing, and sequences misprediction recovery/refill.
module tag_alloc_ctrl #(
  parameter int NUM_LANES  = 4,
  parameter int PTAG_W     = 6,
  parameter int REFILL_MAX = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             IN_mispr,
  input  logic                             IN_flushActive,
  input  logic [NUM_LANES-1:0]             IN_slotValid,
  input  logic [NUM_LANES-1:0][PTAG_W-1:0] IN_slotTag,
  output logic [NUM_LANES-1:0]             OUT_slotTaken,
  input  logic                             IN_groupValid,
  input  logic [NUM_LANES-1:0]             IN_reqValid,
  input  logic                             IN_stall,
  output logic [NUM_LANES-1:0][PTAG_W-1:0] OUT_grantTag,
  output logic                             OUT_ready,
  output logic                             OUT_fire,
  output logic [1:0]                       OUT_state,
  output logic [15:0]                      OUT_tagStallCnt
);

  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int RCNT_W = (REFILL_MAX > 1) ? $clog2(REFILL_MAX) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_REFILL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   refill_cnt_q, refill_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic [CNT_W-1:0]    slot_rank [NUM_LANES];
  logic [CNT_W-1:0]    req_rank  [NUM_LANES];
  logic [CNT_W-1:0]    nslot, nreq;

  // Rank each valid slot and each requesting lane; equal ranks pair up.
  always_comb begin
    nslot = '0;
    nreq  = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      slot_rank[j] = nslot;
      nslot        = nslot + CNT_W'(IN_slotValid[j]);
      req_rank[j]  = nreq;
      nreq         = nreq + CNT_W'(IN_reqValid[j]);
    end
  end

  always_comb begin
    OUT_ready     = (state_q == ST_RUN) && (nslot >= nreq);
    OUT_fire      = OUT_ready && IN_groupValid && !IN_stall && !IN_mispr;
    OUT_grantTag  = '0;
    OUT_slotTaken = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((state_q == ST_RUN) && IN_reqValid[i]) begin
        for (int j = 0; j < NUM_LANES; j++) begin
          if (IN_slotValid[j] && (slot_rank[j] == req_rank[i])) begin
            OUT_grantTag[i] = IN_slotTag[j];
          end
        end
      end
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      OUT_slotTaken[j] = OUT_fire && IN_slotValid[j] && (slot_rank[j] < nreq);
    end
  end

  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (IN_mispr) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!IN_mispr && !IN_flushActive) begin
          state_d      = ST_REFILL;
          refill_cnt_d = '0;
        end
      end
      ST_REFILL: begin
        // A new misprediction wins over a completed refill.
        if (IN_mispr) begin
          state_d = ST_RECOVER;
        end else if ((&IN_slotValid) || (refill_cnt_q == RCNT_W'(REFILL_MAX - 1))) begin
          state_d = ST_RUN;
        end else begin
          refill_cnt_d = refill_cnt_q + RCNT_W'(1);
        end
      end
      default: begin
        state_d      = ST_REFILL;
        refill_cnt_d = '0;
      end
    endcase
    if ((state_q == ST_RUN) && IN_groupValid && !IN_stall && !IN_mispr &&
        (nslot < nreq) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REFILL;
      refill_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign OUT_state       = state_q;
  assign OUT_tagStallCnt = stall_cnt_q;

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Scoreboard bench for tag_alloc_ctrl: a queue-based reference model predicts each cycle's outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_tag_alloc_ctrl;
  localparam int NL = 4;
  localparam int PW = 6;
  localparam int RM = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     IN_mispr, IN_flushActive, IN_groupValid, IN_stall;
  logic [NL-1:0]            IN_slotValid, IN_reqValid, OUT_slotTaken;
  logic [NL-1:0][PW-1:0]    IN_slotTag, OUT_grantTag;
  logic                     OUT_ready, OUT_fire;
  logic [1:0]               OUT_state;
  logic [15:0]              OUT_tagStallCnt;

  always #5 clk = ~clk;

  tag_alloc_ctrl #(.NUM_LANES(NL), .PTAG_W(PW), .REFILL_MAX(RM)) dut (
    .clk(clk), .rst(rst),
    .IN_mispr(IN_mispr), .IN_flushActive(IN_flushActive),
    .IN_slotValid(IN_slotValid), .IN_slotTag(IN_slotTag),
    .OUT_slotTaken(OUT_slotTaken),
    .IN_groupValid(IN_groupValid), .IN_reqValid(IN_reqValid), .IN_stall(IN_stall),
    .OUT_grantTag(OUT_grantTag), .OUT_ready(OUT_ready), .OUT_fire(OUT_fire),
    .OUT_state(OUT_state), .OUT_tagStallCnt(OUT_tagStallCnt)
  );

  typedef struct {
    logic [1:0]            state;
    logic                  ready;
    logic                  fire;
    logic [NL-1:0]         taken;
    logic [NL-1:0][PW-1:0] grant;
    logic [15:0]           scnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          sb_en = 1'b1;

  int          m_state;
  int          m_refill;
  int unsigned m_scnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("state", 32'(OUT_state), 32'(e.state));
      checkOutput("ready", 32'(OUT_ready), 32'(e.ready));
      checkOutput("fire", 32'(OUT_fire), 32'(e.fire));
      checkOutput("slotTaken", 32'(OUT_slotTaken), 32'(e.taken));
      checkOutput("grantTag", 32'(OUT_grantTag), 32'(e.grant));
      checkOutput("tagStallCnt", 32'(OUT_tagStallCnt), 32'(e.scnt));
    end
  end

  // Drives one cycle of inputs, predicts outputs, then advances the model across the clock edge.
  task automatic applyStimulus(input bit r, input bit mi, input bit fl, input logic [NL-1:0] sv,
                               input logic [NL-1:0][PW-1:0] tg, input bit gv,
                               input logic [NL-1:0] rq, input bit st);
    exp_t e;
    int   free_q[$];
    int   nslot;
    int   nreq;
    int   idx;
    rst = r; IN_mispr = mi; IN_flushActive = fl; IN_slotValid = sv; IN_slotTag = tg;
    IN_groupValid = gv; IN_reqValid = rq; IN_stall = st;
    nslot = 0;
    nreq  = 0;
    for (int j = 0; j < NL; j++) begin
      if (sv[j]) begin
        free_q.push_back(j);
        nslot++;
      end
      if (rq[j]) nreq++;
    end
    e.state = 2'(m_state);
    e.ready = (m_state == 0) && (nslot >= nreq);
    e.fire  = e.ready && gv && !st && !mi;
    e.taken = '0;
    e.grant = '0;
    if (m_state == 0) begin
      for (int i = 0; i < NL; i++) begin
        if (rq[i] && free_q.size() > 0) begin
          idx = free_q.pop_front();
          e.grant[i] = tg[idx];
          if (e.fire) e.taken[idx] = 1'b1;
        end
      end
    end
    e.scnt = 16'(m_scnt);
    if (sb_en) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      m_state = 2; m_refill = 0; m_scnt = 0;
    end else begin
      if (m_state == 0 && gv && !st && !mi && nslot < nreq && m_scnt < 65535) m_scnt++;
      case (m_state)
        0: if (mi) m_state = 1;
        1: if (!mi && !fl) begin m_state = 2; m_refill = 0; end
        default: begin
          if (mi) m_state = 1;
          else if (nslot == NL || m_refill == RM - 1) m_state = 0;
          else m_refill++;
        end
      endcase
    end
  endtask

  logic [NL-1:0][PW-1:0] tags;
  logic [NL-1:0][PW-1:0] rtags;

  initial begin
    tags[0] = 6'd10; tags[1] = 6'd11; tags[2] = 6'd12; tags[3] = 6'd13;
    rst = 1'b1; IN_mispr = 0; IN_flushActive = 0; IN_slotValid = '0; IN_slotTag = tags;
    IN_groupValid = 0; IN_reqValid = '0; IN_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    m_state = 2; m_refill = 0; m_scnt = 0;

    // Reset values, then refill completes when all slots turn valid.
    applyStimulus(1, 0, 0, 4'h0, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'h0, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'hF, tags, 0, 4'h0, 0);
    // Sparse request mapping: lanes 1,3 get slots 0,1.
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'b1010, 0);
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'b1111, 0);
    // Tag shortage.
    repeat (3) applyStimulus(0, 0, 0, 4'b0010, tags, 1, 4'b0011, 0);
    // Mispredict with a ready group, flush for 3 cycles, refill.
    applyStimulus(0, 1, 0, 4'hF, tags, 1, 4'b0011, 0);
    repeat (3) applyStimulus(0, 0, 1, 4'hF, tags, 1, 4'b0011, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 1, 4'b0011, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 1, 4'b0011, 0);
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'b0011, 0);
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'b0011, 0);
    // Forced exit from refill, then a mispredict mid-refill restarting the counter.
    applyStimulus(0, 1, 0, 4'hF, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 0, 4'h0, 0);
    repeat (5) applyStimulus(0, 0, 0, 4'b0111, tags, 1, 4'b0001, 0);
    applyStimulus(0, 1, 0, 4'b0111, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 0, 4'h0, 0);
    applyStimulus(0, 1, 0, 4'b0111, tags, 0, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'b0111, tags, 0, 4'h0, 0);
    repeat (5) applyStimulus(0, 0, 0, 4'b0111, tags, 1, 4'b0001, 0);
    // Empty request group with and without stall.
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'h0, 1);
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'h0, 0);
    applyStimulus(0, 0, 0, 4'h0, tags, 1, 4'h0, 0);
    // Drive the stall counter into saturation without per-cycle scoring.
    sb_en = 1'b0;
    repeat (65540) applyStimulus(0, 0, 0, 4'b0010, tags, 1, 4'b0011, 0);
    sb_en = 1'b1;
    repeat (2) applyStimulus(0, 0, 0, 4'b0010, tags, 1, 4'b0011, 0);
    applyStimulus(0, 0, 0, 4'hF, tags, 1, 4'b0011, 0);
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [NL-1:0] rsv;
      for (int i = 0; i < NL; i++) rtags[i] = PW'($urandom);
      rsv = ($urandom_range(0, 2) == 0) ? NL'($urandom) : 4'hF;
      applyStimulus(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), rsv, rtags,
                    1'($urandom), NL'($urandom), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_alloc_ctrl.md
# tag_alloc_ctrl

Allocation controller between the rename stage and the physical-register tag free list. Each cycle it assigns the free list's pre-fetched tag slots to the rename lanes that need a destination register. A group either advances with all of its tags or not at all. The block also sequences recovery after a misprediction: it blocks allocation while the free list is restored and rolled back, then waits for the slots to refill before rename resumes.

## Interface
Parameters:
- NUM_LANES, 4, rename lanes; equals the free list's issue slot count
- PTAG_W, 6, physical tag width (free-list index, no immediate bit)
- REFILL_MAX, 4, maximum cycles spent in REFILL before forcing RUN

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_mispr  in  1  misprediction pulse
- IN_flushActive  in  1  rollback/replay of committed tags in progress (level)
- IN_slotValid[NUM_LANES]  in  1  free-list slot i holds a tag
- IN_slotTag[NUM_LANES]  in  PTAG_W  tag held in slot i
- OUT_slotTaken[NUM_LANES]  out  1  slot i consumed this cycle (drives the free list's issue-valid)
- IN_groupValid  in  1  rename group present
- IN_reqValid[NUM_LANES]  in  1  lane i needs a new tag
- IN_stall  in  1  downstream cannot accept the group
- OUT_grantTag[NUM_LANES]  out  PTAG_W  tag granted to lane i; 0 when not granted
- OUT_ready  out  1  state RUN and enough valid slots for all requests
- OUT_fire  out  1  group accepted this cycle
- OUT_state  out  2  0=RUN, 1=RECOVER, 2=REFILL
- OUT_tagStallCnt  out  16  saturating count of cycles a group was blocked by tag shortage

## Operation
Mapping (combinational, active in RUN only):
- nreq = popcount(IN_reqValid); nslot = popcount(IN_slotValid).
- The k-th requesting lane, in ascending lane index, receives the k-th valid slot, in ascending slot index. Its OUT_grantTag is that slot's IN_slotTag.
- OUT_ready = (state==RUN) && (nslot >= nreq).
- OUT_fire = OUT_ready && IN_groupValid && !IN_stall && !IN_mispr.
- OUT_slotTaken[j] = OUT_fire && slot j assigned to some lane. At most nreq bits are set, and never on an invalid slot.
- A group with nreq=0 fires whenever it is otherwise ready, and takes no slots.
- Outside RUN, or when not firing, OUT_slotTaken = 0. OUT_grantTag is still driven by the mapping in RUN, and is all-zero in other states.

FSM, all transitions on the clk edge:
- RUN -> RECOVER on IN_mispr. IN_mispr always suppresses fire in the same cycle.
- RECOVER holds while IN_mispr || IN_flushActive. It moves to REFILL in the first cycle both inputs are low. The refill counter is cleared on entry.
- REFILL -> RUN when all IN_slotValid bits are set, or when the refill counter equals REFILL_MAX-1. The counter increments each REFILL cycle.
- REFILL -> RECOVER on IN_mispr. IN_mispr takes priority over the exit condition.
- Reset state: REFILL with the counter at 0. The free list produces no valid slots in its first cycle out of reset.

Stall counter:
- Increments when state==RUN && IN_groupValid && !IN_stall && !IN_mispr && nslot < nreq.
- Saturates at 0xFFFF.
- Cleared only by rst.

## Timing
- Reset values: OUT_state=2, OUT_ready=0, OUT_fire=0, OUT_slotTaken all 0, OUT_tagStallCnt=0, OUT_grantTag all 0.
- Allocation has zero latency: grant, fire and slot-taken are combinational from the current-cycle inputs and the registered state.
- The free list invalidates taken slots and refills them at the same edge. Back-to-back groups can therefore fire every cycle while the free list keeps up.
- A mispr in cycle t causes: no fire at t; RECOVER from t+1. The earliest possible RUN is t+3 (one RECOVER cycle, one REFILL cycle whose exit condition holds).
- IN_mispr held for several cycles keeps the block in RECOVER.
- rst takes priority over every other input.

## Test plan
- Reset release, slots become all valid at cycle 2 -> OUT_state 2 until the full-slot cycle, then 0; OUT_tagStallCnt=0.
- RUN; slots valid {1,1,1,1} with tags {10,11,12,13}; req {0,1,0,1}, group valid, no stall -> grants lane1=10, lane3=11; OUT_slotTaken={1,1,0,0}; OUT_fire=1.
- RUN; slots valid {0,1,0,0}; req {1,1,0,0} -> OUT_ready=0, no slot taken, counter +1 per cycle. Counter preloaded at 0xFFFF stays at 0xFFFF.
- IN_mispr together with a ready group -> OUT_fire=0. Then IN_flushActive high for 3 cycles -> RECOVER for those cycles, then REFILL, then RUN when all slots are valid.
- REFILL with slots never all valid -> RUN forced after 4 cycles (REFILL_MAX=4). A mispr at REFILL cycle 2 -> RECOVER, and the counter restarts on re-entry.
- Group with req all 0 and IN_stall=1 -> no fire, no slot taken, counter unchanged. With IN_stall=0 -> fire with no slots taken.
